rgb_column_feeder: RTL and testbench

Front-end for the RGB 3x3 systolic convolution arrays. It accepts a raster-order RGB pixel stream and buffers the two previous image rows in on-chip line buffers. For every pixel of image row 2 onward, it emits the 3x1 vertical column of each colour in the packed format the arrays consume. It also sequences the arrays' one-cycle `load_weight` pulse at the start of each frame.

---
 rtl/rgb_column_feeder.sv | 106 ++++++++++
 tb/tb_rgb_column_feeder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rgb_column_feeder.sv
// rgb_column_feeder: buffers the two previous RGB rows and emits one 3x1 column per colour
// for every pixel of row 2 onward, and strobes load_weight once at frame start.
module rgb_column_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH = 64,
  parameter int IMG_HEIGHT = 48,
  localparam int XW = $clog2(IMG_WIDTH),
  localparam int YW = $clog2(IMG_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [DATA_WIDTH-1:0]   pix_r,
  input  logic [DATA_WIDTH-1:0]   pix_g,
  input  logic [DATA_WIDTH-1:0]   pix_b,
  output logic                    load_weight,
  output logic [3*DATA_WIDTH-1:0] input_col_r,
  output logic [3*DATA_WIDTH-1:0] input_col_g,
  output logic [3*DATA_WIDTH-1:0] input_col_b,
  output logic                    col_valid,
  output logic [XW-1:0]           col_x,
  output logic [YW-1:0]           col_y,
  output logic                    busy,
  output logic                    frame_done
);
  localparam int DW = DATA_WIDTH;
  localparam int PW = 3 * DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, LOAD, FILL, STREAM, DONE} state_t;
  state_t state, next_state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [PW-1:0] lb0 [IMG_WIDTH];
  logic [PW-1:0] lb1 [IMG_WIDTH];
  logic [PW-1:0] pix, old0, old1;
  logic accept, last_x, last_y, emit, ready_d, load_d, done_d;
  assign pix    = {pix_r, pix_g, pix_b};
  assign old0   = lb0[x];
  assign old1   = lb1[x];
  assign accept = pix_valid && pix_ready;
  assign last_x = x == XW'(IMG_WIDTH - 1);
  assign last_y = y == YW'(IMG_HEIGHT - 1);
  assign emit   = accept && state == STREAM;
  assign busy   = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? LOAD : IDLE;
      LOAD:    next_state = FILL;
      FILL:    next_state = (accept && last_x && y == YW'(1)) ? STREAM : FILL;
      STREAM:  next_state = (accept && last_x && last_y) ? DONE : STREAM;
      default: next_state = IDLE;
    endcase
  end
  // Registered outputs are driven from the next state so they line up with the state itself.
  always_comb begin
    ready_d = next_state == FILL || next_state == STREAM;
    load_d  = next_state == LOAD;
    done_d  = next_state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (state == LOAD) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      x <= last_x ? '0 : x + XW'(1);
      y <= last_x ? y + YW'(1) : y;
    end
  // Read-before-write: the column uses the old contents, then rows shift down by one.
  always_ff @(posedge clk)
    if (accept) begin
      lb1[x] <= old0;
      lb0[x] <= pix;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pix_ready   <= 1'b0;
      load_weight <= 1'b0;
      frame_done  <= 1'b0;
      col_valid   <= 1'b0;
      col_x       <= '0;
      col_y       <= '0;
      input_col_r <= '0;
      input_col_g <= '0;
      input_col_b <= '0;
    end else begin
      pix_ready   <= ready_d;
      load_weight <= load_d;
      frame_done  <= done_d;
      col_valid   <= emit;
      if (emit) begin
        col_x       <= x;
        col_y       <= y;
        input_col_r <= {pix_r, old0[PW-1 -: DW], old1[PW-1 -: DW]};
        input_col_g <= {pix_g, old0[2*DW-1 -: DW], old1[2*DW-1 -: DW]};
        input_col_b <= {pix_b, old0[DW-1:0], old1[DW-1:0]};
      end
    end
endmodule

// File: tb/tb_rgb_column_feeder.sv
// tb_rgb_column_feeder: directed frames on a 4x4 image checked against a pixel-column model.
module tb_rgb_column_feeder;
  localparam int DW = 8, W = 4, H = 4;
  logic clk = 0, rst = 1, start = 0, pix_valid = 0;
  logic [DW-1:0] pix_r = 0, pix_g = 0, pix_b = 0;
  logic pix_ready, load_weight, col_valid, busy, frame_done;
  logic [3*DW-1:0] input_col_r, input_col_g, input_col_b;
  logic [1:0] col_x, col_y;
  typedef struct {logic [23:0] r, g, b; int x, y;} col_t;
  col_t exp_q[$];
  int n_vec = 0, n_bad = 0, col_cnt = 0, lw_cnt = 0;
  logic [23:0] first_r, first_g, first_b, last_r;
  int first_x, first_y, last_x, last_y;

  rgb_column_feeder #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .load_weight(load_weight),
    .input_col_r(input_col_r), .input_col_g(input_col_g), .input_col_b(input_col_b),
    .col_valid(col_valid), .col_x(col_x), .col_y(col_y), .busy(busy), .frame_done(frame_done));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pv(input int base, input int x, input int y, input int c);
    return 8'(base + 16 * y + x + c);
  endfunction

  always @(negedge clk) begin
    col_t e;
    if (load_weight) lw_cnt++;
    if (col_valid) begin
      if (exp_q.size() == 0) check("unexpected_col", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("col_r", input_col_r, e.r);
        check("col_g", input_col_g, e.g);
        check("col_b", input_col_b, e.b);
        check("col_x", col_x, e.x);
        check("col_y", col_y, e.y);
        if (col_cnt == 0) begin
          first_r = input_col_r; first_g = input_col_g; first_b = input_col_b;
          first_x = col_x; first_y = col_y;
        end
        last_r = input_col_r; last_x = col_x; last_y = col_y;
        col_cnt++;
      end
    end
  end

  task automatic start_frame();
    start = 1; col_cnt = 0; lw_cnt = 0;
    @(negedge clk); start = 0;
    check("load_weight_t1", load_weight, 1);
    check("ready_t1", pix_ready, 0);
  endtask

  task automatic send_frame(input int base, input int gap, input int start_at, input int stop_at);
    int x = 0, y = 0, idx = 0, cyc = 0;
    col_t e;
    while (y < H && idx != stop_at && cyc < 400) begin
      @(negedge clk); cyc++;
      pix_valid = (gap == 0) || ($urandom_range(99) >= gap);
      start = start_at >= 0 && (idx == start_at || idx == start_at + 6);
      pix_r = pv(base, x, y, 0); pix_g = pv(base, x, y, 1); pix_b = pv(base, x, y, 2);
      if (pix_valid && pix_ready) begin
        if (y >= 2) begin
          e.r = {pv(base, x, y, 0), pv(base, x, y - 1, 0), pv(base, x, y - 2, 0)};
          e.g = {pv(base, x, y, 1), pv(base, x, y - 1, 1), pv(base, x, y - 2, 1)};
          e.b = {pv(base, x, y, 2), pv(base, x, y - 1, 2), pv(base, x, y - 2, 2)};
          e.x = x; e.y = y;
          exp_q.push_back(e);
        end
        if (x == W - 1) begin x = 0; y++; end else x++;
        idx++;
      end
    end
    if (cyc >= 400) check("frame_timeout", 0, 1);
  endtask

  task automatic end_frame(input int ncol);
    @(negedge clk); pix_valid = 0; start = 0;
    check("frame_done", frame_done, 1);
    check("ready_in_done", pix_ready, 0);
    check("busy_in_done", busy, 1);
    @(negedge clk);
    check("frame_done_clear", frame_done, 0);
    check("busy_idle", busy, 0);
    #1;
    check("col_count", col_cnt, ncol);
    check("load_weight_count", lw_cnt, 1);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    #23;
    check("rst_ready", pix_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_col_valid", col_valid, 0);
    check("rst_load_weight", load_weight, 0);
    check("rst_frame_done", frame_done, 0);
    @(negedge clk); rst = 0;
    @(negedge clk);
    check("post_rst_ready", pix_ready, 0);
    check("post_rst_busy", busy, 0);
    #1;
    // Frame A: continuous pixels, hand-computed first and last columns.
    start_frame();
    send_frame(0, 0, -1, -1);
    end_frame(8);
    check("first_r", first_r, 24'h201000);
    check("first_g", first_g, 24'h211101);
    check("first_b", first_b, 24'h221202);
    check("last_x", last_x, 3);
    check("last_y", last_y, 3);
    check("last_r", last_r, 24'h332313);
    // Frame B: same data with ~40% gaps.
    start_frame();
    send_frame(0, 40, -1, -1);
    end_frame(8);
    check("gap_first_r", first_r, 24'h201000);
    check("gap_last_r", last_r, 24'h332313);
    // Frame C: start pulses in FILL and STREAM must be ignored.
    start_frame();
    send_frame(8'h40, 0, 3, -1);
    end_frame(8);
    // Frame D: aborted by reset while streaming at (2,2).
    start_frame();
    send_frame(8'h80, 0, -1, 10);
    @(negedge clk); pix_valid = 0;
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("mid_rst_ready", pix_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_col_valid", col_valid, 0);
    check("mid_rst_col_r", input_col_r, 0);
    check("mid_rst_col_x", col_x, 0);
    @(negedge clk); rst = 0;
    exp_q.delete();
    @(negedge clk);
    check("restart_idle_ready", pix_ready, 0);
    check("restart_idle_busy", busy, 0);
    #1;
    // Frame E: fresh frame after the abort.
    start_frame();
    send_frame(8'hC0, 0, -1, -1);
    end_frame(8);
    check("restart_first_x", first_x, 0);
    check("restart_first_y", first_y, 2);
    check("restart_first_r", first_r, 24'hE0D0C0);
    // Frame F: back-to-back start in the cycle after DONE.
    start_frame();
    send_frame(8'h10, 25, -1, -1);
    end_frame(8);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
